load_queue_issue: RTL

//  Parametrised circular load queue between dispatch and the data-memory port of the superscalar core.

---
 rtl/load_queue_issue.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/load_queue_issue.sv
// Circular load queue between dispatch and the data-memory port. It holds loads in program order,
// presents the head to the operand stage, and issues it once operands are ready and memory is free.
module load_queue_issue #(
  parameter  int DEPTH = 16,
  parameter  int TAG_W = 32,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [31:0]      enq_instr,
  input  logic [TAG_W-1:0] enq_tag,
  output logic             cand_valid,
  output logic [4:0]       cand_rs,
  output logic [4:0]       cand_rt,
  output logic [15:0]      cand_offset,
  output logic [TAG_W-1:0] cand_tag,
  input  logic             opnd_ready,
  input  logic             mem_stall,
  output logic             iss_valid,
  output logic [31:0]      iss_instr,
  output logic [TAG_W-1:0] iss_tag,
  output logic             illegal_op,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  // Opcode classes accepted by the load unit: LW, LB, LH, LBU, LHU.
  function automatic logic is_load(input logic [5:0] op);
    case (op)
      6'b100011, 6'b100000, 6'b100001, 6'b100100, 6'b100101: is_load = 1'b1;
      default:                                                is_load = 1'b0;
    endcase
  endfunction

  logic [31:0]      instr_mem_q [DEPTH];
  logic [TAG_W-1:0] tag_mem_q   [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             iss_valid_q, iss_valid_d;
  logic [31:0]      iss_instr_q, iss_instr_d;
  logic [TAG_W-1:0] iss_tag_q, iss_tag_d;
  logic             illegal_q, illegal_d;

  logic [31:0]      head_instr_s;
  logic [TAG_W-1:0] head_tag_s;
  logic             head_legal_s;
  logic             empty_s, full_s;
  logic             push_s, issue_s, discard_s, pop_s;

  assign head_instr_s = instr_mem_q[head_q];
  assign head_tag_s   = tag_mem_q[head_q];
  assign head_legal_s = is_load(head_instr_s[31:26]);
  assign empty_s      = (count_q == CNT_W'(0));
  assign full_s       = (count_q == CNT_W'(DEPTH));

  // Full blocks enqueue even if the head pops on the same edge.
  assign push_s    = enq_valid && !full_s;
  assign issue_s   = !empty_s && head_legal_s && opnd_ready && !mem_stall;
  assign discard_s = !empty_s && !head_legal_s;
  assign pop_s     = issue_s || discard_s;

  // Next-state for pointers, occupancy and the registered issue/discard pulses.
  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    iss_valid_d = 1'b0;
    iss_instr_d = iss_instr_q;
    iss_tag_d   = iss_tag_q;
    illegal_d   = 1'b0;
    if (flush) begin
      head_d  = {PTR_W{1'b0}};
      tail_d  = {PTR_W{1'b0}};
      count_d = {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        tail_d = tail_q + PTR_W'(1);
      end else begin
        tail_d = tail_q;
      end
      if (pop_s) begin
        head_d = head_q + PTR_W'(1);
      end else begin
        head_d = head_q;
      end
      if (push_s && !pop_s) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop_s && !push_s) begin
        count_d = count_q - CNT_W'(1);
      end else begin
        count_d = count_q;
      end
      if (issue_s) begin
        iss_valid_d = 1'b1;
        iss_instr_d = head_instr_s;
        iss_tag_d   = head_tag_s;
      end else begin
        iss_valid_d = 1'b0;
      end
      illegal_d = discard_s;
    end
  end

  // State registers; synchronous reset takes priority over flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= {PTR_W{1'b0}};
      tail_q      <= {PTR_W{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      iss_valid_q <= 1'b0;
      iss_instr_q <= 32'd0;
      iss_tag_q   <= {TAG_W{1'b0}};
      illegal_q   <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      iss_valid_q <= iss_valid_d;
      iss_instr_q <= iss_instr_d;
      iss_tag_q   <= iss_tag_d;
      illegal_q   <= illegal_d;
    end
  end

  // Entry storage has no reset; occupancy alone decides which slots are meaningful.
  always_ff @(posedge clk) begin
    if (push_s && !flush && !rst) begin
      instr_mem_q[tail_q] <= enq_instr;
      tag_mem_q[tail_q]   <= enq_tag;
    end
  end

  assign enq_ready   = !full_s;
  assign cand_valid  = !empty_s && head_legal_s;
  assign cand_rs     = head_instr_s[25:21];
  assign cand_rt     = head_instr_s[20:16];
  assign cand_offset = head_instr_s[15:0];
  assign cand_tag    = head_tag_s;
  assign iss_valid   = iss_valid_q;
  assign iss_instr   = iss_instr_q;
  assign iss_tag     = iss_tag_q;
  assign illegal_op  = illegal_q;
  assign count       = count_q;
  assign full        = full_s;
  assign empty       = empty_s;

endmodule
